// File: rtl/finaladder_pkg.sv
// Shared constants and segment-geometry helpers for the pipelined final adder.
package finaladder_pkg;

  localparam int DEF_WIDTH  = 27;
  localparam int DEF_STAGES = 3;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction

  function automatic int seg_hi(input int k, input int seg, input int width);
    return ((((k + 1) * seg) < width) ? ((k + 1) * seg) : width) - 1;
  endfunction

  // Zero means the segment starts at or above the top bit and only forwards data.
  function automatic int seg_width(input int k, input int seg, input int width);
    return (seg_lo(k, seg) >= width) ? 0 : seg_hi(k, seg, width) - seg_lo(k, seg) + 1;
  endfunction

endpackage

// File: rtl/cpa_segment.sv
// Combinational ripple-carry segment of W bits used by one pipeline stage.
module cpa_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      // Per-bit carry nets keep the chain as distinct signals rather than one looping vector.
      logic c_in;
      logic c_out;
      if (gi == 0) begin : g_lsb
        assign c_in = cin;
      end else begin : g_upper
        assign c_in = g_bit[gi-1].c_out;
      end
      fulladder u_fa (
        .a   (a[gi]),
        .b   (b[gi]),
        .cin (c_in),
        .s   (s[gi]),
        .cout(c_out)
      );
    end
  endgenerate

  assign cout = g_bit[W-1].c_out;

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell built from two half adders.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1, c1, c2;

  halfadder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  halfadder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;

endmodule

// File: rtl/halfadder.sv
// One-bit half adder cell.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/pipelined_final_adder.sv
// Pipelined carry-propagate adder with valid/ready flow control; one carry segment per stage.
// Optional FINALADDER_APPROX_EN: low APPROX_LSBS sum bits become a|b with no carry out of them.
module pipelined_final_adder
  import finaladder_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STAGES      = DEF_STAGES,
  parameter int APPROX_LSBS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s
);

  localparam int SEG = ceil_div(WIDTH, STAGES);

  generate
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
      $error("pipelined_final_adder: STAGES must lie in 1..WIDTH");
    end
    if (APPROX_LSBS < 0 || APPROX_LSBS >= WIDTH) begin : g_bad_approx
      $error("pipelined_final_adder: APPROX_LSBS must lie in 0..WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] a_first;
  logic [WIDTH-1:0] b_first;
  logic [WIDTH-1:0] sum_first;

`ifdef FINALADDER_APPROX_EN
  // Zeroed low operands make the exact chain produce zeros and no carry there; the OR bits are merged in.
  localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - APPROX_LSBS);
  assign a_first   = a & ~LOW_MASK;
  assign b_first   = b & ~LOW_MASK;
  assign sum_first = (a | b) & LOW_MASK;
`else
  assign a_first   = a;
  assign b_first   = b;
  assign sum_first = '0;
`endif

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_carry;
  logic [STAGES-1:0] load_ok;
  logic [WIDTH-1:0]  stage_sum [STAGES];
  logic [WIDTH-1:0]  stage_a   [STAGES];
  logic [WIDTH-1:0]  stage_b   [STAGES];

  // A stage may load when it is empty or everything downstream of it moves this cycle.
  always_comb begin
    load_ok = '0;
    load_ok[STAGES-1] = ~stage_valid[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load_ok[k] = ~stage_valid[k] | load_ok[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = seg_lo(gi, SEG);
      localparam int SW = seg_width(gi, SEG, WIDTH);

      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
      logic [WIDTH-1:0] sum_in;
      logic [WIDTH-1:0] sum_next;
      logic             carry_in;
      logic             carry_next;
      logic             valid_in;
      logic             valid_reg;
      logic             carry_reg;
      logic [WIDTH-1:0] sum_reg;
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;

      if (gi == 0) begin : g_head
        assign op_a     = a_first;
        assign op_b     = b_first;
        assign sum_in   = sum_first;
        assign carry_in = 1'b0;
        assign valid_in = in_valid;
      end else begin : g_body
        assign op_a     = stage_a[gi-1];
        assign op_b     = stage_b[gi-1];
        assign sum_in   = stage_sum[gi-1];
        assign carry_in = stage_carry[gi-1];
        assign valid_in = stage_valid[gi-1];
      end

      if (SW > 0) begin : g_add
        logic [SW-1:0] seg_s;
        cpa_segment #(.W(SW)) u_cpa (
          .a   (SW'(op_a >> LO)),
          .b   (SW'(op_b >> LO)),
          .cin (carry_in),
          .s   (seg_s),
          .cout(carry_next)
        );
        assign sum_next = sum_in | (WIDTH'(seg_s) << LO);
      end else begin : g_pass
        assign sum_next   = sum_in;
        assign carry_next = carry_in;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
          a_reg     <= '0;
          b_reg     <= '0;
        end else if (load_ok[gi]) begin
          valid_reg <= valid_in;
          if (valid_in) begin
            carry_reg <= carry_next;
            sum_reg   <= sum_next;
            a_reg     <= op_a;
            b_reg     <= op_b;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_carry[gi] = carry_reg;
      assign stage_sum[gi]   = sum_reg;
      assign stage_a[gi]     = a_reg;
      assign stage_b[gi]     = b_reg;
    end
  endgenerate

  assign in_ready  = load_ok[0];
  assign out_valid = stage_valid[STAGES-1];
  assign s         = {stage_carry[STAGES-1], stage_sum[STAGES-1]};

endmodule

// File: tb/tb_pipelined_final_adder.sv
// Scoreboard bench: drivers push expected sums, monitors pop and compare on each output beat.
module tb_pipelined_final_adder;

  localparam int W  = 27;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [W:0]   s;

  logic         aux_valid;
  logic [9:0]   xa, xb;
  logic [26:0]  pa, pb;
  logic         r3_ready, r3_ov, r1_ready, r1_ov, p_ready, p_ov;
  logic [10:0]  r3_s, r1_s;
  logic [27:0]  p_s;

  always #5 clk = ~clk;

  pipelined_final_adder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  pipelined_final_adder #(.WIDTH(10), .STAGES(3)) u_w10s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(r3_ready), .a(xa), .b(xb),
    .out_valid(r3_ov), .out_ready(1'b1), .s(r3_s)
  );

  pipelined_final_adder #(.WIDTH(10), .STAGES(1)) u_w10s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(r1_ready), .a(xa), .b(xb),
    .out_valid(r1_ov), .out_ready(1'b1), .s(r1_s)
  );

  pipelined_final_adder #(.WIDTH(27), .STAGES(3), .APPROX_LSBS(4)) u_apx (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(p_ready), .a(pa), .b(pb),
    .out_valid(p_ov), .out_ready(1'b1), .s(p_s)
  );

  typedef struct {
    logic [63:0] exp;
    int          acc;
    bit          lat;
  } item_t;

  item_t q_main[$];
  item_t q_w3[$];
  item_t q_w1[$];
  item_t q_apx[$];

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  bit         holding = 1'b0;
  logic [W:0] hold_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0h, expected nothing pending here", name, act);
  endtask

  function automatic logic [W:0] add(input logic [W-1:0] va, input logic [W-1:0] vb);
    return {1'b0, va} + {1'b0, vb};
  endfunction

  // Main-DUT monitor, sampled 2 time units after the falling edge.
  always @(negedge clk) begin
    item_t it;
    #2;
    if (rst_n && out_valid) begin
      if (!out_ready) begin
        if (holding) check("stall_hold_s", s, hold_s);
        hold_s  = s;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
        if (q_main.size() == 0) begin
          miss("main_unexpected_output", s);
        end else begin
          it = q_main.pop_front();
          check("main_sum", s, it.exp);
          if (it.lat) check("main_latency", cyc - it.acc, ST);
          $display("main result cycle=%0d s=%h expected=%h", cyc, s, it.exp[W:0]);
        end
      end
    end else begin
      holding = 1'b0;
    end
  end

  always @(negedge clk) begin
    item_t it;
    #2;
    if (rst_n && r3_ov) begin
      if (q_w3.size() == 0) miss("w10s3_unexpected", r3_s);
      else begin
        it = q_w3.pop_front();
        check("w10s3_sum", r3_s, it.exp);
        check("w10s3_latency", cyc - it.acc, 3);
        $display("w10s3 result cycle=%0d s=%h expected=%h", cyc, r3_s, it.exp[10:0]);
      end
    end
    if (rst_n && r1_ov) begin
      if (q_w1.size() == 0) miss("w10s1_unexpected", r1_s);
      else begin
        it = q_w1.pop_front();
        check("w10s1_sum", r1_s, it.exp);
        check("w10s1_latency", cyc - it.acc, 1);
        $display("w10s1 result cycle=%0d s=%h expected=%h", cyc, r1_s, it.exp[10:0]);
      end
    end
    if (rst_n && p_ov) begin
      if (q_apx.size() == 0) miss("approx_unexpected", p_s);
      else begin
        it = q_apx.pop_front();
        check("approx_sum", p_s, it.exp);
        check("approx_latency", cyc - it.acc, 3);
        $display("approx result cycle=%0d s=%h expected=%h", cyc, p_s, it.exp[27:0]);
      end
    end
  end

  task automatic push(inout item_t q[$], input logic [63:0] exp, input bit lat);
    item_t it;
    it.exp = exp;
    it.acc = cyc;
    it.lat = lat;
    q.push_back(it);
  endtask

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W:0] exp,
                      input bit lat, input bit need_ready);
    int tries;
    tries = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = va;
    b = vb;
    #1;
    if (need_ready) check("in_ready_back_to_back", in_ready, 1'b1);
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) miss("accept_timeout", in_ready);
    else push(q_main, 64'(exp), lat);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_main.size() + q_w3.size() + q_w1.size() + q_apx.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) miss(name, 64'(q_main.size()));
    repeat (2) @(negedge clk);
  endtask

  logic [W-1:0] dir_a [4] = '{27'h7FFFFFF, 27'h0000000, 27'h7FFFFFF, 27'h5555555};
  logic [W-1:0] dir_b [4] = '{27'h0000001, 27'h0000000, 27'h7FFFFFF, 27'h2AAAAAB};
  logic [W:0]   dir_s [4] = '{28'h8000000, 28'h0000000, 28'hFFFFFFE, 28'h8000000};

  initial begin
    int           accepted;
    logic [W-1:0] va, vb;
    logic [27:0]  apx_exp;

    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    aux_valid = 1'b0; xa = '0; xb = '0; pa = '0; pb = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_s", s, '0);
    check("reset_in_ready", in_ready, 1'b1);

    // Directed vectors: full carry ripple, zero, maximum, alternating patterns.
    for (int i = 0; i < 4; i++) begin
      send(dir_a[i], dir_b[i], dir_s[i], 1'b1, 1'b0);
      idle();
      drain("drain_directed");
    end

    for (int i = 0; i < 100; i++) begin
      va = W'($urandom);
      vb = W'($urandom);
      send(va, vb, add(va, vb), 1'b1, 1'b1);
    end
    idle();
    drain("drain_back_to_back");

    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = W'(i * 1000 + 27'h4000005);
      b = W'(i * 3 + 7);
      #1;
      if (in_ready) begin
        push(q_main, 64'(add(a, b)), 1'b0);
        accepted++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("stall_accept_count", accepted, 3);
    check("stall_in_ready", in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    drain("drain_stall");

    send(27'h1234567, 27'h0FEDCBA, add(27'h1234567, 27'h0FEDCBA), 1'b1, 1'b0);
    send(27'h7000000, 27'h1000000, add(27'h7000000, 27'h1000000), 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_s", s, '0);
    q_main.delete();
    rst_n = 1'b1;
    send(27'h0ABCDEF, 27'h0111111, add(27'h0ABCDEF, 27'h0111111), 1'b1, 1'b0);
    idle();
    drain("drain_after_reset");

`ifdef FINALADDER_APPROX_EN
    apx_exp = 28'h000000F;
`else
    apx_exp = 28'h0000010;
`endif
    @(negedge clk);
    aux_valid = 1'b1;
    xa = 10'h3FF; xb = 10'h3FF;
    pa = 27'h00F; pb = 27'h001;
    #1;
    check("w10s3_in_ready", r3_ready, 1'b1);
    check("w10s1_in_ready", r1_ready, 1'b1);
    check("approx_in_ready", p_ready, 1'b1);
    push(q_w3, 64'h7FE, 1'b1);
    push(q_w1, 64'h7FE, 1'b1);
    push(q_apx, 64'(apx_exp), 1'b1);
    @(negedge clk);
    aux_valid = 1'b0;
    drain("drain_aux");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_final_adder.md
Name: pipelined_final_adder

Overview:
- Parametrised, pipelined carry-propagate adder for the last stage of the compressor-based multiplier. It adds the two rows left after 4:2 compression and produces the final product.
- The carry chain is split into STAGES register-separated segments. This gives an adder of any width with one result per cycle and a valid/ready handshake.
- Sits between the compressor tree output registers and the product consumer. Replaces fixed-width combinational ripple adders.

Parameters:
- WIDTH, 27, operand width in bits; sum is WIDTH+1 bits.
- STAGES, 3, number of pipeline segments (1..WIDTH); this is also the latency in cycles.
- APPROX_LSBS, 0, number of low sum bits computed approximately; only used when FINALADDER_APPROX_EN is defined; legal range 0..WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  first compressed row.
- b  input  WIDTH  second compressed row.
- out_valid  output  1  s is valid.
- out_ready  input  1  consumer accepts s this cycle.
- s  output  WIDTH+1  sum a+b; s[WIDTH] is the carry-out.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values: when rst_n=0 at a clk edge, all stage valid bits clear, out_valid=0, s=0. in_ready=1 in the first cycle after reset.
- Reset during operation: all in-flight results are discarded and no out_valid is asserted for them.
- Segmentation:
  - SEG = ceil(WIDTH/STAGES).
  - Segment k covers bits [k*SEG, min((k+1)*SEG, WIDTH)-1]. The last segment may be narrower.
  - Any segment that would start at or above WIDTH is empty and passes data through unchanged.
- Stage k (k = 0..STAGES-1) register contents:
  - Sum bits produced so far.
  - Carry out of segment k.
  - Unconsumed operand bits of a and b above segment k.
  - A valid bit.
- Stage k logic: ripple-adds segment k of the forwarded operands plus the incoming carry. Stage 0 has carry-in 0.
- Final stage: its register is the output register. s[WIDTH] is the carry out of the top segment.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, provided out_ready stays high.
- Throughput: one result per cycle.
- Handshake and stalls:
  - Stage k advances when its successor is empty or advancing. The last stage advances when !out_valid | out_ready.
  - in_ready = stage0 empty | stage0 advancing. This is purely combinational from the stage valids and out_ready.
  - A stalled stage holds its contents.
  - No bubbles are inserted when all stages are full and out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, s must not change.
- Input rules: in_valid may be asserted while in_ready=0; the operands are simply not taken that cycle. a and b are sampled only on an accepting edge.
- Ordering: results leave in input order; nothing is dropped or duplicated.
- Overflow: impossible by construction, since the sum is WIDTH+1 bits.
- STAGES=1: a single registered ripple adder with the same handshake.

Optional Feature:
- Macro: FINALADDER_APPROX_EN.
- Defined, with APPROX_LSBS = K > 0:
  - Sum bits [K-1:0] = a[K-1:0] | b[K-1:0].
  - Carry into bit K is forced to 0.
  - Bits K and above are exact as above.
  - This shortens the chain for the approximate-multiplier configurations.
- Undefined: APPROX_LSBS is ignored and the adder is exact.
- Latency and handshake are identical in both cases.

Decomposition:
- Package finaladder_pkg:
  - Function for ceil division, used to derive SEG.
  - Localparam helpers for segment low/high indices.
  - Default WIDTH/STAGES constants shared with the multiplier top.
- Sub-module cpa_segment:
  - Parametrised combinational ripple adder (width, carry-in, sum, carry-out).
  - Built from the existing halfadder/fulladder cells; one instance per stage.
- Control: the valid/advance chain is a generate loop in the top.

Test Plan:
- Defaults, a=27'h7FFFFFF, b=27'h0000001, out_ready=1 -> s=28'h8000000 with out_valid exactly 3 cycles after acceptance. Confirms the full carry ripple across all segments.
- 100 back-to-back random pairs, out_ready=1 -> 100 results in order, one per cycle, every s equal to a+b; in_ready stays 1.
- out_ready=0 for 6 cycles with in_valid=1 continuously -> exactly 3 operands accepted, then in_ready=0 and s held stable. On out_ready=1, results drain in order with no loss.
- rst_n=0 for one cycle while 2 results are in flight -> out_valid=0 and s=0 next cycle; the old results never appear; a new input issued afterwards emerges 3 cycles later.
- WIDTH=10, STAGES=3 (segments 4,4,2), a=10'h3FF, b=10'h3FF -> s=11'h7FE; STAGES=1 with the same operands -> s=11'h7FE after 1 cycle.
- FINALADDER_APPROX_EN defined, APPROX_LSBS=4, a=27'h00F, b=27'h001 -> s=28'h000000F; macro undefined, same operands -> s=28'h0000010.
